// File: rtl/rpc2_ctrl_axi_rd_data_control_pkg.sv
// Shared definitions for the AXI read-data return path of the RPC2 controller.
package rpc2_ctrl_axi_rd_data_control_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Map the IP per-word error flag onto an AXI response code.
  function automatic logic [1:0] resp_for(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/rpc2_ctrl_rd_lane_mask.sv
// Lane strobe helper: next-beat strobe rotation and byte-to-bit mask expansion.
module rpc2_ctrl_rd_lane_mask #(
  parameter int NB = 4
) (
  input  logic [NB-1:0]   strb,
  input  logic [1:0]      size,
  output logic [NB-1:0]   strb_next,
  output logic [8*NB-1:0] bit_mask
);

  localparam logic [3:0] NB_L = 4'(NB);

  logic [3:0]      step;
  logic [2*NB-1:0] dbl;

  assign step = 4'd1 << size;
  // Shifting the doubled strobe leaves the rotated copy in the upper half.
  assign dbl  = {strb, strb} << step;

  // A beat as wide as the bus always covers every lane afterwards, even when
  // the first beat was an unaligned partial word.
  always_comb begin
    strb_next = dbl[2*NB-1:NB];
    if (step >= NB_L) begin
      strb_next = '1;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign bit_mask[8*g +: 8] = {8{strb[g]}};
  end

endmodule

// File: rtl/rpc2_ctrl_axi_rd_data_control.sv
// AXI read-data channel controller: pops per-burst descriptors, shapes IP read
// words into R beats (lane masking, RID/RRESP/RLAST) and paces the IP source.
module rpc2_ctrl_axi_rd_data_control
  import rpc2_ctrl_axi_rd_data_control_pkg::*;
#(
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          arid_fifo_empty,
  input  logic [C_AXI_ID_WIDTH-1:0]     arid_id,
  input  logic [7:0]                    arid_len,
  input  logic [1:0]                    arid_size,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] arid_strb,
  output logic                          arid_fifo_rd_en,
  input  logic                          rdat_valid,
  input  logic [C_AXI_DATA_WIDTH-1:0]   rdat_data,
  input  logic                          rdat_err,
  output logic                          rdat_ready,
  output logic [C_AXI_ID_WIDTH-1:0]     AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
  output logic [1:0]                    AXI_RRESP,
  output logic                          AXI_RLAST,
  output logic                          AXI_RVALID,
  input  logic                          AXI_RREADY
);

  localparam int NB = C_AXI_DATA_WIDTH / 8;

  rd_state_t                   state_q;
  rd_state_t                   state_nxt;
  logic [C_AXI_ID_WIDTH-1:0]   id_q;
  logic [7:0]                  len_q;
  logic [1:0]                  size_q;
  logic [NB-1:0]               strb_q;
  logic [7:0]                  cnt_q;
  logic [NB-1:0]               strb_next;
  logic [C_AXI_DATA_WIDTH-1:0] bit_mask;
  logic                        slot_free;
  logic                        load;
  logic                        last_beat;

  rpc2_ctrl_rd_lane_mask #(
    .NB(NB)
  ) u_lane_mask (
    .strb      (strb_q),
    .size      (size_q),
    .strb_next (strb_next),
    .bit_mask  (bit_mask)
  );

  assign slot_free = !AXI_RVALID || AXI_RREADY;
  assign last_beat = (cnt_q == len_q);
  assign load      = (state_q == ST_BURST) && slot_free && rdat_valid;
  // The IP word is retired only once its top lane has been sent or the burst ends.
  assign rdat_ready = load && (strb_q[NB-1] || last_beat);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and descriptor pop decode.
  always_comb begin
    state_nxt       = state_q;
    arid_fifo_rd_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!arid_fifo_empty && reset_n) begin
          arid_fifo_rd_en = 1'b1;
          state_nxt       = ST_BURST;
        end
      end
      ST_BURST: begin
        if (load && last_beat) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Burst registers: captured on pop, strobe and beat count advanced per load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_q   <= '0;
      len_q  <= '0;
      size_q <= '0;
      strb_q <= '0;
      cnt_q  <= '0;
    end else if (arid_fifo_rd_en) begin
      id_q   <= arid_id;
      len_q  <= arid_len;
      size_q <= arid_size;
      strb_q <= arid_strb;
      cnt_q  <= '0;
    end else if (load) begin
      strb_q <= strb_next;
      cnt_q  <= cnt_q + 8'd1;
    end
  end

  // R channel output slot; contents only change when the slot is free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      AXI_RVALID <= 1'b0;
      AXI_RLAST  <= 1'b0;
      AXI_RRESP  <= RESP_OKAY;
      AXI_RID    <= '0;
      AXI_RDATA  <= '0;
    end else if (load) begin
      AXI_RVALID <= 1'b1;
      AXI_RLAST  <= last_beat;
      AXI_RRESP  <= resp_for(rdat_err);
      AXI_RID    <= id_q;
      AXI_RDATA  <= rdat_data & bit_mask;
    end else if (slot_free) begin
      AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rpc2_ctrl_axi_rd_data_control.sv
// Scoreboard bench for rpc2_ctrl_axi_rd_data_control: a descriptor FIFO and an
// IP word source are modelled with queues; expected R beats are derived from
// the descriptor and pushed when stimulus is issued, and a monitor compares.
module tb_rpc2_ctrl_axi_rd_data_control;

  localparam int IDW = 4;
  localparam int DW  = 32;
  localparam int NB  = DW / 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            arid_fifo_empty = 1'b1;
  logic [IDW-1:0]  arid_id = '0;
  logic [7:0]      arid_len = '0;
  logic [1:0]      arid_size = '0;
  logic [NB-1:0]   arid_strb = '0;
  logic            arid_fifo_rd_en;
  logic            rdat_valid = 1'b0;
  logic [DW-1:0]   rdat_data = '0;
  logic            rdat_err = 1'b0;
  logic            rdat_ready;
  logic [IDW-1:0]  AXI_RID;
  logic [DW-1:0]   AXI_RDATA;
  logic [1:0]      AXI_RRESP;
  logic            AXI_RLAST;
  logic            AXI_RVALID;
  logic            AXI_RREADY = 1'b0;

  rpc2_ctrl_axi_rd_data_control #(
    .C_AXI_ID_WIDTH   (IDW),
    .C_AXI_DATA_WIDTH (DW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .arid_fifo_empty (arid_fifo_empty),
    .arid_id         (arid_id),
    .arid_len        (arid_len),
    .arid_size       (arid_size),
    .arid_strb       (arid_strb),
    .arid_fifo_rd_en (arid_fifo_rd_en),
    .rdat_valid      (rdat_valid),
    .rdat_data       (rdat_data),
    .rdat_err        (rdat_err),
    .rdat_ready      (rdat_ready),
    .AXI_RID         (AXI_RID),
    .AXI_RDATA       (AXI_RDATA),
    .AXI_RRESP       (AXI_RRESP),
    .AXI_RLAST       (AXI_RLAST),
    .AXI_RVALID      (AXI_RVALID),
    .AXI_RREADY      (AXI_RREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     len;
    logic [1:0]     size;
    logic [NB-1:0]  strb;
  } desc_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } word_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } beat_t;

  desc_t desc_q[$];
  word_t word_q[$];
  beat_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int rv_pct = 100;
  int rr_pct = 100;
  bit stall  = 1'b0;
  int hs_count   = 0;
  int word_pops  = 0;
  int desc_pops  = 0;
  bit pop_desc_l = 1'b0;
  bit pop_word_l = 1'b0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] expand(input logic [NB-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Reference model: walk the beats of a burst at byte-lane level. A fresh IP
  // word is needed at the start and after any beat that used the top lane.
  task automatic push_desc(input logic [IDW-1:0] id, input logic [7:0] len, input logic [1:0] size,
                           input logic [NB-1:0] strb, input int err_word);
    logic [NB-1:0] m;
    int    bytes;
    bit    need;
    int    widx;
    word_t w;
    beat_t b;
    desc_t d;
    bytes = 1 << size;
    m     = strb;
    need  = 1'b1;
    widx  = 0;
    w.data = '0;
    w.err  = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      if (need) begin
        w.data = $urandom;
        w.err  = (err_word == -2) ? ($urandom_range(3) == 0) : (widx == err_word);
        word_q.push_back(w);
        widx++;
        need = 1'b0;
      end
      b.id   = id;
      b.data = w.data & expand(m);
      b.resp = w.err ? 2'b10 : 2'b00;
      b.last = (k == int'(len));
      exp_q.push_back(b);
      if (m[NB-1] || k == int'(len)) need = 1'b1;
      if (bytes >= NB) m = '1;
      else m = (m << bytes) | (m >> (NB - bytes));
    end
    d.id = id; d.len = len; d.size = size; d.strb = strb;
    desc_q.push_back(d);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || desc_q.size() != 0 || AXI_RVALID) && n < budget) begin
      step();
      n++;
    end
    check(n < budget, {name, "_drain"}, 64'(n), 64'(budget));
    check(word_q.size() == 0, {name, "_words_left"}, 64'(word_q.size()), 64'd0);
  endtask

  // Latch the pop requests the DUT presents in this cycle.
  always @(negedge clk) begin
    pop_desc_l = arid_fifo_rd_en;
    pop_word_l = rdat_ready;
  end

  // FIFO / IP source driver: apply pops taken at the edge, then present heads.
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      if (pop_desc_l) begin
        check(desc_q.size() > 0, "desc_pop_nonempty", 64'(desc_q.size()), 64'd1);
        if (desc_q.size() > 0) void'(desc_q.pop_front());
        desc_pops++;
      end
      if (pop_word_l) begin
        check(word_q.size() > 0, "word_pop_nonempty", 64'(word_q.size()), 64'd1);
        if (word_q.size() > 0) void'(word_q.pop_front());
        word_pops++;
      end
    end
    arid_fifo_empty = (desc_q.size() == 0);
    if (desc_q.size() > 0) begin
      arid_id   = desc_q[0].id;
      arid_len  = desc_q[0].len;
      arid_size = desc_q[0].size;
      arid_strb = desc_q[0].strb;
    end
    rdat_valid = (word_q.size() > 0) && (int'($urandom_range(99)) < rv_pct);
    if (word_q.size() > 0) begin
      rdat_data = word_q[0].data;
      rdat_err  = word_q[0].err;
    end else begin
      rdat_data = $urandom;
      rdat_err  = 1'b0;
    end
    AXI_RREADY = !stall && (int'($urandom_range(99)) < rr_pct);
  end

  beat_t e;
  beat_t prev;
  bit    prev_stalled = 1'b0;
  bit    prev_rd_en = 1'b0;

  // Monitor: scoreboard compare on handshake plus protocol checks.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stalled = 1'b0;
      prev_rd_en   = 1'b0;
    end else begin
      if (arid_fifo_rd_en) begin
        check(!arid_fifo_empty, "rd_en_while_empty", 64'(arid_fifo_empty), 64'd0);
        check(!prev_rd_en, "rd_en_single_pulse", 64'(prev_rd_en), 64'd0);
      end
      prev_rd_en = arid_fifo_rd_en;
      if (rdat_ready) check(rdat_valid, "rdat_ready_without_valid", 64'(rdat_valid), 64'd1);
      if (prev_stalled) begin
        check(AXI_RVALID && AXI_RID == prev.id && AXI_RDATA == prev.data &&
              AXI_RRESP == prev.resp && AXI_RLAST == prev.last,
              "stall_stable", {AXI_RDATA, 28'd0, AXI_RID}, {prev.data, 28'd0, prev.id});
      end
      if (AXI_RVALID && !AXI_RREADY) begin
        check(!rdat_ready, "rdat_ready_in_stall", 64'(rdat_ready), 64'd0);
        prev_stalled = 1'b1;
        prev.id   = AXI_RID;
        prev.data = AXI_RDATA;
        prev.resp = AXI_RRESP;
        prev.last = AXI_RLAST;
      end else begin
        prev_stalled = 1'b0;
      end
      if (AXI_RVALID && AXI_RREADY) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", {AXI_RDATA, 28'd0, AXI_RID}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check(AXI_RDATA == e.data, "rdata", 64'(AXI_RDATA), 64'(e.data));
          check(AXI_RRESP == e.resp, "rresp", 64'(AXI_RRESP), 64'(e.resp));
          check(AXI_RID == e.id, "rid", 64'(AXI_RID), 64'(e.id));
          check(AXI_RLAST == e.last, "rlast", 64'(AXI_RLAST), 64'(e.last));
        end
        hs_count++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs0, wp0, dp0, n;
    logic [1:0]    sz;
    logic [NB-1:0] sb;
    int bytes, lane;

    reset_n = 1'b0;
    repeat (3) step();
    check(AXI_RVALID == 1'b0, "rst_rvalid", 64'(AXI_RVALID), 64'd0);
    check(AXI_RLAST == 1'b0, "rst_rlast", 64'(AXI_RLAST), 64'd0);
    check(AXI_RRESP == 2'b00, "rst_rresp", 64'(AXI_RRESP), 64'd0);
    check(AXI_RID == '0, "rst_rid", 64'(AXI_RID), 64'd0);
    check(AXI_RDATA == '0, "rst_rdata", 64'(AXI_RDATA), 64'd0);
    check(arid_fifo_rd_en == 1'b0, "rst_rd_en", 64'(arid_fifo_rd_en), 64'd0);
    check(rdat_ready == 1'b0, "rst_rdat_ready", 64'(rdat_ready), 64'd0);
    reset_n = 1'b1;
    step();

    // Full-width 4-beat burst.
    wp0 = word_pops; dp0 = desc_pops;
    push_desc(4'h1, 8'd3, 2'd2, 4'hF, -1);
    drain("full4", 200);
    check(word_pops - wp0 == 4, "full4_word_pops", 64'(word_pops - wp0), 64'd4);
    check(desc_pops - dp0 == 1, "full4_desc_pops", 64'(desc_pops - dp0), 64'd1);

    // Byte beats starting at lane 1: masks 2,4,8,1; word retired on beats 3 and 4.
    wp0 = word_pops;
    push_desc(4'h2, 8'd3, 2'd0, 4'h2, -1);
    drain("narrow", 200);
    check(word_pops - wp0 == 2, "narrow_word_pops", 64'(word_pops - wp0), 64'd2);

    // Back-to-back single-beat bursts.
    push_desc(4'h3, 8'd0, 2'd2, 4'hF, -1);
    push_desc(4'h5, 8'd0, 2'd2, 4'hF, -1);
    drain("b2b", 200);

    // Error on the middle beat only.
    push_desc(4'h6, 8'd2, 2'd2, 4'hF, 1);
    drain("err_mid", 200);

    // Stall of 5 cycles mid-burst.
    hs0 = hs_count;
    push_desc(4'h7, 8'd7, 2'd2, 4'hF, -1);
    n = 0;
    while (hs_count < hs0 + 2 && n < 200) begin step(); n++; end
    check(n < 200, "stall_reach", 64'(n), 64'd200);
    stall = 1'b1;
    repeat (6) step();
    check(AXI_RVALID == 1'b1, "stall_rvalid_held", 64'(AXI_RVALID), 64'd1);
    stall = 1'b0;
    drain("stall", 200);

    // Longest burst: 256 beats.
    push_desc(4'h8, 8'd255, 2'd2, 4'hF, -2);
    drain("len255", 2000);

    // Reset while beat 2 of an 8-beat burst is presented.
    hs0 = hs_count;
    push_desc(4'h9, 8'd7, 2'd2, 4'hF, -1);
    n = 0;
    while (hs_count < hs0 + 1 && n < 200) begin step(); n++; end
    check(n < 200, "rst_reach", 64'(n), 64'd200);
    step();
    check(AXI_RVALID == 1'b1, "rst_beat2_valid", 64'(AXI_RVALID), 64'd1);
    reset_n = 1'b0;
    #1;
    check(AXI_RVALID == 1'b0, "midrst_rvalid", 64'(AXI_RVALID), 64'd0);
    check(rdat_ready == 1'b0, "midrst_rdat_ready", 64'(rdat_ready), 64'd0);
    check(arid_fifo_rd_en == 1'b0, "midrst_rd_en", 64'(arid_fifo_rd_en), 64'd0);
    desc_q.delete();
    word_q.delete();
    exp_q.delete();
    repeat (3) step();
    reset_n = 1'b1;
    step();
    push_desc(4'hA, 8'd3, 2'd1, 4'hC, -1);
    drain("after_rst", 200);

    // Randomized traffic with random valid/ready pacing.
    rv_pct = 70;
    rr_pct = 65;
    for (int i = 0; i < 40; i++) begin
      sz    = 2'($urandom_range(2));
      bytes = 1 << sz;
      if (bytes >= NB) begin
        lane = $urandom_range(NB - 1);
        sb   = '1;
        sb   = sb << lane;
      end else begin
        lane = $urandom_range(NB / bytes - 1) * bytes;
        sb   = NB'((1 << bytes) - 1) << lane;
      end
      push_desc(IDW'($urandom), 8'($urandom_range(15)), sz, sb, -2);
      if ($urandom_range(3) == 0) drain("rand", 3000);
    end
    drain("rand_final", 5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
